// File: rtl/brew_sequencer_if.sv
// Handshake and recipe bus between the price/recipe front end and the brew sequencer.
// The master side drives start/recipe/pause/abort; the slave side (the sequencer) drives status and valves.
interface brew_sequencer_if #(
    parameter int N_ING  = 5,
    parameter int ING_W  = 3,
    parameter int TIME_W = 8
);
    logic                       comparador_de_precio_ok;
    logic [1:0]                 c_type;
    logic [4*N_ING-1:0]         recipe_cfg;
    logic [N_ING*TIME_W-1:0]    dose_time;
    logic                       pause;
    logic                       abort;
    logic                       busy;
    logic [N_ING-1:0]           valve;
    logic [ING_W-1:0]           ing_type;
    logic                       step_start;
    logic                       done;
    logic                       aborted;

    modport master (
        output comparador_de_precio_ok, c_type, recipe_cfg, dose_time, pause, abort,
        input  busy, valve, ing_type, step_start, done, aborted
    );

    modport slave (
        input  comparador_de_precio_ok, c_type, recipe_cfg, dose_time, pause, abort,
        output busy, valve, ing_type, step_start, done, aborted
    );
endinterface

// File: rtl/brew_sequencer.sv
// Recipe sequencer: scans the latched ingredient mask and opens one valve at a time for its dose time.
// Every output is a flop computed from the next state, so outputs line up with the state they describe.
module brew_sequencer #(
    parameter int N_ING  = 5,
    parameter int ING_W  = 3,
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    brew_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEEK = 2'd1,
        S_DISP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [ING_W-1:0] LAST_IDX = ING_W'(N_ING - 1);
    localparam logic [N_ING-1:0] VALVE0   = N_ING'(1);

    state_e              state_q, state_d;
    logic [ING_W-1:0]    idx_q, idx_d;
    logic [TIME_W-1:0]   timer_q, timer_d;
    logic [N_ING-1:0]    mask_q, mask_d;
    logic [TIME_W-1:0]   dose_sel_s;

    logic                busy_q, busy_d;
    logic [N_ING-1:0]    valve_q, valve_d;
    logic [ING_W-1:0]    ing_type_q, ing_type_d;
    logic                step_start_q, step_start_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    assign dose_sel_s = bus.dose_time[idx_q*TIME_W +: TIME_W];

    // Next-state logic for the scan/dispense sequence; abort outranks pause and timer expiry.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        mask_d    = mask_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.comparador_de_precio_ok) begin
                    mask_d  = bus.recipe_cfg[bus.c_type*N_ING +: N_ING];
                    idx_d   = {ING_W{1'b0}};
                    state_d = S_SEEK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEEK: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (mask_q[idx_q]) begin
                    state_d = S_DISP;
                    // A zero dose still opens the valve for one cycle.
                    timer_d = (dose_sel_s == {TIME_W{1'b0}}) ? TIME_W'(1) : dose_sel_s;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + ING_W'(1);
                end
            end
            S_DISP: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (bus.pause) begin
                    timer_d = timer_q;
                end else if (timer_q == TIME_W'(1)) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ING_W'(1);
                        state_d = S_SEEK;
                    end
                end else begin
                    timer_d = timer_q - TIME_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values derived from the upcoming state so the flops present them in that state's cycle.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        valve_d      = {N_ING{1'b0}};
        ing_type_d   = ing_type_q;
        step_start_d = 1'b0;
        done_d       = (state_d == S_DONE);
        if (state_d == S_DISP) begin
            valve_d      = VALVE0 << idx_d;
            ing_type_d   = idx_d;
            step_start_d = (state_q != S_DISP);
        end else begin
            valve_d = {N_ING{1'b0}};
        end
    end

    // State, sequencing and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= {ING_W{1'b0}};
            timer_q      <= {TIME_W{1'b0}};
            mask_q       <= {N_ING{1'b0}};
            busy_q       <= 1'b0;
            valve_q      <= {N_ING{1'b0}};
            ing_type_q   <= {ING_W{1'b0}};
            step_start_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            mask_q       <= mask_d;
            busy_q       <= busy_d;
            valve_q      <= valve_d;
            ing_type_q   <= ing_type_d;
            step_start_q <= step_start_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.valve      = valve_q;
    assign bus.ing_type   = ing_type_q;
    assign bus.step_start = step_start_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;

endmodule
